// File: rtl/serial_subtractor.sv
`default_nettype none
// serial_subtractor: bit-serial A - B - bin through one full-subtractor cell,
// one bit per clock LSB first, with a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             bout,
    output logic             ovf
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST     = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  PRE_LAST = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic             br;
    logic             br_msb;
    logic [CW-1:0]    count;

    logic             a_bit;
    logic             b_bit;
    logic             diff;
    logic             br_next;
    logic [WIDTH-1:0] d_next;

    always_comb begin
        a_bit   = a_sr[0];
        b_bit   = b_sr[0];
        diff    = a_bit ^ b_bit ^ br;
        br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
        // New difference bit enters at the MSB; the low bit falls off.
        d_next  = WIDTH'({diff, d_sr} >> 1);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            d_sr   <= '0;
            br     <= 1'b0;
            br_msb <= 1'b0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            D      <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= A;
                        b_sr   <= B;
                        br     <= bin;
                        br_msb <= 1'b0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    d_sr  <= d_next;
                    br    <= br_next;
                    count <= count + 1'b1;
                    // Borrow into the sign bit; xor with borrow-out flags signed overflow.
                    if (count == PRE_LAST) begin
                        br_msb <= br_next;
                    end
                    if (count == LAST) begin
                        D     <= d_next;
                        bout  <= br_next;
                        ovf   <= br_msb ^ br_next;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// tb_serial_subtractor: directed stimulus with an expected-result queue for
// serial_subtractor (WIDTH=16).
module tb_serial_subtractor;

    localparam int WIDTH = 16;

    logic             Clk;
    logic             Reset_n;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             bout;
    logic             ovf;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .D       (D),
        .bout    (bout),
        .ovf     (ovf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bo;
        logic             ov;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned difference mod 2^(WIDTH+1) and signed range test.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic bi);
        exp_t             e;
        logic [WIDTH:0]   u;
        int               s;
        u    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bi};
        s    = int'($signed(a)) - int'($signed(b)) - int'(bi);
        e.d  = u[WIDTH-1:0];
        e.bo = u[WIDTH];
        e.ov = (s < -(2 ** (WIDTH - 1))) || (s > (2 ** (WIDTH - 1)) - 1);
        return e;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    // Drive operands with start high, accept on the next edge; cyc counts from there.
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic bi, input bit push, input bit hold);
        @(negedge Clk);
        A     = a;
        B     = b;
        bin   = bi;
        start = 1'b1;
        if (push) q.push_back(model(a, b, bi));
        @(posedge Clk);
        #1;
        cyc = 0;
        if (!hold) start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_done();
        while (!done && cyc < WIDTH + 8) tick();
        if (!done) begin
            total++;
            bad++;
            $error("FAIL done_timeout observed=0 expected=1 after %0d cycles", cyc);
        end
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_sb_empty observed=result expected=none", tag);
        end else begin
            e = q.pop_front();
            chk({tag, "_D"},    32'(D),    32'(e.d));
            chk({tag, "_bout"}, 32'(bout), 32'(e.bo));
            chk({tag, "_ovf"},  32'(ovf),  32'(e.ov));
        end
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic bi);
        launch(a, b, bi, 1'b1, 1'b0);
        wait_done();
        chk({tag, "_latency"}, 32'(cyc), 32'(WIDTH));
        check_result(tag);
        tick();
        chk({tag, "_done_width"}, 32'(done), 32'd0);
        chk({tag, "_busy_fall"},  32'(busy), 32'd0);
    endtask

    initial begin
        int gap;
        int seen;
        Reset_n = 1'b0;
        start   = 1'b0;
        A       = '0;
        B       = '0;
        bin     = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_D",    32'(D),    32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_ovf",  32'(ovf),  32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Directed operations, including signed-overflow corners.
        run_op("op1234", 16'h1234, 16'h0234, 1'b0);
        run_op("op0m1",  16'h0000, 16'h0001, 1'b0);
        run_op("ovf_neg", 16'h8000, 16'h0001, 1'b0);
        run_op("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0);

        // Borrow-in; a start pulse mid-run with new A must be ignored.
        launch(16'h0005, 16'h0005, 1'b1, 1'b1, 1'b0);
        repeat (4) tick();
        A     = 16'h0009;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        chk("bin_latency", 32'(cyc), 32'(WIDTH));
        check_result("bin");
        seen = 0;
        repeat (WIDTH + 4) begin
            tick();
            if (done || busy) seen++;
        end
        chk("no_queued_op", 32'(seen), 32'd0);
        chk("bin_D_held",   32'(D),    32'h0000FFFF);

        // Back-to-back with start held: issue period WIDTH+2.
        launch(16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b1);
        A = 16'h0001;
        B = 16'h0002;
        q.push_back(model(16'h0001, 16'h0002, 1'b0));
        wait_done();
        chk("b2b_first_latency", 32'(cyc), 32'(WIDTH));
        check_result("b2b_first");
        gap = 0;
        do begin
            @(posedge Clk);
            #1;
            gap++;
            if (gap == 2) start = 1'b0;
        end while (!done && gap < 2 * WIDTH);
        chk("b2b_gap", 32'(gap), 32'(WIDTH + 2));
        check_result("b2b_second");
        tick();

        // Asynchronous abort mid-run.
        launch(16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0);
        repeat (8) tick();
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_D",    32'(D),    32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        chk("abort_ovf",  32'(ovf),  32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        seen = 0;
        repeat (WIDTH + 4) begin
            tick();
            if (done) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        run_op("after_abort", 16'h4321, 16'h1234, 1'b1);

        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
